lsu_memreq: RTL and testbench
=============================

Name: lsu_memreq

Overview:
- Load/store request sequencer directly upstream of the load-data converter.
- Accepts one load/store at a time from the execute stage over a valid/ready handshake and issues a word-aligned bus access with byte strobes.
- Places store data in the correct byte lanes and waits for the memory ack.
- Returns the raw read word plus its size code and address offset, which the downstream converter uses for lane extraction.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles before a bus timeout (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_bmul  in  2  size: 00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_strb  out  4  byte strobes, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-placed store data
- mem_ack  in  1  bus completion
- mem_rdata  in  32  bus read word
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  raw read word (0 for stores/errors)
- rsp_bmul  out  2  registered req_bmul
- rsp_aoff  out  2  registered req_addr[1:0]
- rsp_err  out  1  misaligned/illegal (or timeout)

Behaviour:
- Lane map is big-endian: byte offset a -> lane 3-a.
  - Byte: strb = 1 << (3-a); wdata byte replicated to all lanes.
  - Half: a=0 -> strb 1100, a=2 -> strb 0011; halfword replicated to both halves.
  - Word: strb 1111.
- Fault at accept:
  - bmul=11;
  - half with a[0]=1;
  - word with a!=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational, IDLE only).
  - On req_valid, latch we/bmul/addr/wdata.
  - Fault -> RESP with err=1; no bus access occurs.
  - Otherwise -> WAIT.
- WAIT:
  - mem_req=1; mem_we/mem_addr/mem_strb/mem_wdata are registered and held stable until an ack.
  - On mem_ack: capture mem_rdata into rsp_data if load, else 0; -> RESP.
  - Ack may arrive in the first WAIT cycle, so the minimum is 3 cycles per access.
- RESP:
  - rsp_valid=1 for exactly one cycle, then -> IDLE.
  - rsp_* fields hold their values until the next RESP.
- mem_ack outside WAIT is ignored.
- mem_req is low in IDLE and RESP.
- Back-to-back requests: a new request is accepted in the IDLE cycle after RESP.
- Reset values: state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_strb=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_bmul=0, rsp_aoff=0, rsp_err=0.
- Reset mid-WAIT: mem_req drops the next cycle and the transaction is abandoned with no response. The memory must tolerate an abandoned request.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle without an ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with rsp_err=1 and rsp_data=0.
  - An ack in the same cycle as the timeout wins; the access completes normally.
- Undefined: WAIT persists indefinitely; no counter logic is present.

Test Plan:
- Load byte, addr 0x1003, ack on the 1st WAIT cycle, rdata 0xAABBCCDD -> mem_addr 0x1000, strb 0001, we 0; rsp_valid 2 cycles after accept; rsp_data 0xAABBCCDD, bmul 00, aoff 11, err 0.
- Store half 0x00001234 @0x2002, ack after 3 WAIT cycles -> strb 0011, wdata 0x12341234; signals stable for all WAIT cycles; rsp_data 0, err 0.
- Store word @0x3001 -> no mem_req; rsp_valid the cycle after accept with err 1; req_ready returns the following cycle.
- Two back-to-back loads with req_valid held high -> second accept occurs exactly on the IDLE cycle after the first rsp_valid; spurious mem_ack during IDLE has no effect.
- rst asserted during WAIT -> mem_req 0 on the next cycle; no rsp_valid; all outputs at reset values.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 WAIT cycles; rsp_valid with err 1, rsp_data 0.

Source files
------------

// File: rtl/lsu_memreq.sv
// lsu_memreq: load/store request sequencer feeding the load-data converter.
// Takes one load/store at a time over a valid/ready handshake and issues a
// word-aligned bus access with big-endian byte strobes. It returns the raw
// read word together with the size code and byte offset, which the
// downstream converter uses to extract the right lanes.
// Optional feature: define LSU_TIMEOUT_EN to abandon a bus access that has
// not been acknowledged within TIMEOUT_CYCLES wait cycles and report an error.
module lsu_memreq #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // execute-stage request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_bmul,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // response to the load-data converter
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_bmul,
    output logic [1:0]  rsp_aoff,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] BMUL_BYTE = 2'b00;
    localparam logic [1:0] BMUL_HALF = 2'b01;
    localparam logic [1:0] BMUL_WORD = 2'b10;

    state_t      state;
    state_t      state_nxt;

    logic        accept;      // request taken this cycle
    logic        fault;       // incoming request is misaligned or illegal
    logic [3:0]  lane_strb;   // strobes for the incoming request
    logic [31:0] lane_wdata;  // store data placed on its byte lanes
    logic        timed_out;   // wait budget exhausted without an ack
    logic        finish;      // the bus access ends this cycle

    // request fields kept for the response
    logic        lat_we;
    logic [1:0]  lat_bmul;
    logic [1:0]  lat_aoff;

    // Handshake and bus request come straight from the state.
    assign req_ready = (state == IDLE);
    assign mem_req   = (state == WAIT);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);
    assign finish    = (state == WAIT) && (mem_ack || timed_out);

    // Decode size/offset into lane strobes, lane-placed data and alignment fault.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        lane_strb  = 4'b0000;
        lane_wdata = req_wdata;
        fault      = 1'b0;
        case (req_bmul)
            BMUL_BYTE: begin
                // big-endian: byte offset a lives on lane 3-a
                lane_strb  = 4'b1000 >> req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            BMUL_HALF: begin
                lane_strb  = req_addr[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{req_wdata[15:0]}};
                fault      = req_addr[0];
            end
            BMUL_WORD: begin
                lane_strb  = 4'b1111;
                fault      = |req_addr[1:0];
            end
            default: begin
                fault      = 1'b1;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    // At least 8 bits, wider if the budget needs it.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count the wait cycles that pass without an ack; cleared as WAIT is entered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before this edge.
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // This wait cycle is the last one in the budget; an ack in the same cycle wins.
    assign timed_out = (state == WAIT) && !mem_ack && (wait_cnt == CNT_LAST);
`else
    // Without the timeout feature WAIT only ends on an ack.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timed_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = fault ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_ack || timed_out) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Keep the request fields and load the bus signals at accept; they stay put through WAIT.
    always_ff @(posedge clk) begin
        // NOTE: every output register is reset, so a reset during WAIT drops
        // the access and leaves nothing stale on the bus.
        if (rst) begin
            lat_we    <= 1'b0;
            lat_bmul  <= 2'b00;
            lat_aoff  <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_strb  <= 4'b0000;
            mem_wdata <= '0;
        end else if (accept) begin
            lat_we   <= req_we;
            lat_bmul <= req_bmul;
            lat_aoff <= req_addr[1:0];
            // a faulting request never reaches the bus
            if (!fault) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_strb  <= lane_strb;
                mem_wdata <= lane_wdata;
            end
        end
    end

    // Load the response fields as RESP is entered; they hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_bmul <= 2'b00;
            rsp_aoff <= 2'b00;
            rsp_err  <= 1'b0;
        end else if (accept && fault) begin
            rsp_data <= '0;
            rsp_bmul <= req_bmul;
            rsp_aoff <= req_addr[1:0];
            rsp_err  <= 1'b1;
        end else if (finish) begin
            // stores and timeouts return zero data
            rsp_data <= (mem_ack && !lat_we) ? mem_rdata : 32'h0;
            rsp_bmul <= lat_bmul;
            rsp_aoff <= lat_aoff;
            rsp_err  <= !mem_ack;
        end
    end

endmodule

// File: tb/tb_lsu_memreq.sv
// tb_lsu_memreq: directed bench for lsu_memreq with a response scoreboard.
// Expected responses are queued when a request is driven and are compared
// when rsp_valid appears. Bus-side signals are checked in place. Outputs are
// sampled 1 time unit after each rising edge. Define LSU_TIMEOUT_EN to run
// the timeout step instead of the step that checks WAIT persists.
module tb_lsu_memreq;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  bmul;
        logic [1:0]  aoff;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bmul;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_bmul;
    logic [1:0]  rsp_aoff;
    logic        rsp_err;

    rsp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   n_pushed = 0;

    lsu_memreq #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_bmul  (req_bmul),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_bmul  (rsp_bmul),
        .rsp_aoff  (rsp_aoff),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; count response pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) n_rsp++;
    endtask

    task automatic push_rsp(input logic [31:0] data, input logic [1:0] bmul,
                            input logic [1:0] aoff, input logic err);
        rsp_t r;
        r.data = data;
        r.bmul = bmul;
        r.aoff = aoff;
        r.err  = err;
        sb.push_back(r);
        n_pushed++;
    endtask

    // Called in a cycle where a response must be presented.
    task automatic expect_rsp(input string tag);
        rsp_t r;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.scoreboard: observed empty queue expected a queued response", tag);
        end else begin
            r = sb.pop_front();
            check({tag, ".rsp_data"}, rsp_data, r.data);
            check({tag, ".rsp_bmul"}, 32'(rsp_bmul), 32'(r.bmul));
            check({tag, ".rsp_aoff"}, 32'(rsp_aoff), 32'(r.aoff));
            check({tag, ".rsp_err"}, 32'(rsp_err), 32'(r.err));
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] bmul,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_bmul  = bmul;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".mem_req"},   32'(mem_req),   32'd0);
        check({tag, ".mem_we"},    32'(mem_we),    32'd0);
        check({tag, ".mem_addr"},  mem_addr,       32'd0);
        check({tag, ".mem_strb"},  32'(mem_strb),  32'd0);
        check({tag, ".mem_wdata"}, mem_wdata,      32'd0);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_data"},  rsp_data,       32'd0);
        check({tag, ".rsp_bmul"},  32'(rsp_bmul),  32'd0);
        check({tag, ".rsp_aoff"},  32'(rsp_aoff),  32'd0);
        check({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_bmul  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // ---- reset state ----
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle.req_ready", 32'(req_ready), 32'd1);
        check("idle.mem_req",   32'(mem_req),   32'd0);

        // ---- load byte @0x1003, ack in the first WAIT cycle ----
        drive_req(1'b0, 2'b00, 32'h0000_1003, 32'h0);
        check("lb.req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("lb.mem_req",  32'(mem_req), 32'd1);
        check("lb.mem_we",   32'(mem_we),  32'd0);
        check("lb.mem_addr", mem_addr,     32'h0000_1000);
        check("lb.mem_strb", 32'(mem_strb), 32'(4'b0001));
        check("lb.rsp_valid_early", 32'(rsp_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAABB_CCDD;
        push_rsp(32'hAABB_CCDD, 2'b00, 2'b11, 1'b0);
        tick();
        mem_ack = 1'b0;
        expect_rsp("lb");
        check("lb.mem_req_resp",   32'(mem_req),   32'd0);
        check("lb.req_ready_resp", 32'(req_ready), 32'd0);
        tick();
        check("lb.rsp_valid_after", 32'(rsp_valid), 32'd0);
        check("lb.req_ready_after", 32'(req_ready), 32'd1);
        check("lb.rsp_data_hold",   rsp_data,       32'hAABB_CCDD);

        // ---- store half 0x1234 @0x2002, ack on the 3rd WAIT cycle ----
        drive_req(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234);
        tick();
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;  // must not disturb the held bus data
        mem_rdata = 32'hDEAD_BEEF;  // must not reach rsp_data for a store
        for (int i = 0; i < 3; i++) begin
            check("sh.mem_req",   32'(mem_req),   32'd1);
            check("sh.mem_we",    32'(mem_we),    32'd1);
            check("sh.mem_addr",  mem_addr,       32'h0000_2000);
            check("sh.mem_strb",  32'(mem_strb),  32'(4'b0011));
            check("sh.mem_wdata", mem_wdata,      32'h1234_1234);
            if (i == 2) begin
                mem_ack = 1'b1;
                push_rsp(32'h0, 2'b01, 2'b10, 1'b0);
            end
            tick();
        end
        mem_ack = 1'b0;
        expect_rsp("sh");
        tick();

        // ---- misaligned store word @0x3001: error, no bus access ----
        drive_req(1'b1, 2'b10, 32'h0000_3001, 32'h1357_9BDF);
        push_rsp(32'h0, 2'b10, 2'b01, 1'b1);
        tick();
        req_valid = 1'b0;
        expect_rsp("sw_mis");
        check("sw_mis.mem_req",   32'(mem_req),   32'd0);
        check("sw_mis.req_ready", 32'(req_ready), 32'd0);
        tick();
        check("sw_mis.req_ready_after", 32'(req_ready), 32'd1);
        check("sw_mis.mem_req_after",   32'(mem_req),   32'd0);

        // ---- illegal size code: error, no bus access ----
        drive_req(1'b0, 2'b11, 32'h0000_3100, 32'h0);
        push_rsp(32'h0, 2'b11, 2'b00, 1'b1);
        tick();
        req_valid = 1'b0;
        expect_rsp("ill");
        check("ill.mem_req", 32'(mem_req), 32'd0);
        tick();

        // ---- back-to-back loads with req_valid held, spurious ack while idle ----
        drive_req(1'b0, 2'b10, 32'h0000_4000, 32'h0);
        tick();
        drive_req(1'b0, 2'b01, 32'h0000_4006, 32'h0);  // next request, valid stays high
        check("b2b1.mem_addr", mem_addr,      32'h0000_4000);
        check("b2b1.mem_strb", 32'(mem_strb), 32'(4'b1111));
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        push_rsp(32'h1111_2222, 2'b10, 2'b00, 1'b0);
        tick();
        expect_rsp("b2b1");
        check("b2b1.req_ready_resp", 32'(req_ready), 32'd0);
        mem_rdata = 32'h9999_9999;  // ack stays high: spurious outside WAIT
        tick();
        check("b2b.idle_req_ready", 32'(req_ready), 32'd1);
        check("b2b.idle_mem_req",   32'(mem_req),   32'd0);
        check("b2b.idle_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        check("b2b2.mem_req",   32'(mem_req),   32'd1);
        check("b2b2.mem_addr",  mem_addr,       32'h0000_4004);
        check("b2b2.mem_strb",  32'(mem_strb),  32'(4'b0011));
        check("b2b2.rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("b2b2.mem_req_wait", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_6666;
        push_rsp(32'h5555_6666, 2'b01, 2'b10, 1'b0);
        tick();
        mem_ack = 1'b0;
        expect_rsp("b2b2");
        tick();

        // ---- spurious ack with no request in flight ----
        mem_ack = 1'b1;
        tick();
        tick();
        check("spur.mem_req",   32'(mem_req),   32'd0);
        check("spur.rsp_valid", 32'(rsp_valid), 32'd0);
        mem_ack = 1'b0;
        tick();

        // ---- reset during WAIT: access abandoned, no response ----
        drive_req(1'b0, 2'b00, 32'h0000_5001, 32'h0);
        tick();
        req_valid = 1'b0;
        check("rstw.mem_req",  32'(mem_req),  32'd1);
        check("rstw.mem_strb", 32'(mem_strb), 32'(4'b0100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rstw");
        mem_ack = 1'b1;  // late ack after the abandoned access
        tick();
        mem_ack = 1'b0;
        tick();
        check("rstw.rsp_valid_after", 32'(rsp_valid), 32'd0);
        check("rstw.mem_req_after",   32'(mem_req),   32'd0);

`ifdef LSU_TIMEOUT_EN
        // ---- no ack: bus access gives up after 4 WAIT cycles ----
        drive_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
        mem_rdata = 32'h7777_8888;
        tick();
        req_valid = 1'b0;
        push_rsp(32'h0, 2'b10, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("tmo.mem_req", 32'(mem_req), 32'd1);
            tick();
        end
        check("tmo.mem_req_drop", 32'(mem_req), 32'd0);
        expect_rsp("tmo");
        tick();
        check("tmo.req_ready_after", 32'(req_ready), 32'd1);
`else
        // ---- no ack: WAIT persists until a reset ----
        drive_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("nack.mem_req",   32'(mem_req),   32'd1);
        check("nack.mem_addr",  mem_addr,       32'h0000_6000);
        check("nack.req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("nack.req_ready_after_rst", 32'(req_ready), 32'd1);
`endif

        // ---- every queued response appeared and nothing extra did ----
        check("end.rsp_count", 32'(n_rsp), 32'(n_pushed));
        check("end.sb_empty",  32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
